// File: rtl/ahb_lite_slave_regbank.sv
// ahb_lite_slave_regbank: AHB-Lite slave front end producing single-cycle register strobes.
// Optional feature macro AHB_SLV_ERR_EN: bad transfers get a two-cycle ERROR response.
module ahb_lite_slave_regbank #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int N_REGS      = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                      hclk,
    input  logic                      hreset,
    input  logic                      hsel,
    input  logic [31:0]               haddr,
    input  logic [1:0]                htrans,
    input  logic                      hwrite,
    input  logic [2:0]                hsize,
    input  logic [DATA_W-1:0]         hwdata,
    input  logic                      hready,
    output logic                      hreadyout,
    output logic [1:0]                hresp,
    output logic [DATA_W-1:0]         hrdata,
    output logic [$clog2(N_REGS)-1:0] reg_addr,
    output logic                      reg_we,
    output logic [DATA_W/8-1:0]       reg_be,
    output logic [DATA_W-1:0]         reg_wdata,
    output logic                      reg_re,
    input  logic [DATA_W-1:0]         reg_rdata
);
    localparam int BW = DATA_W / 8;
    localparam int OW = $clog2(BW);
    localparam int AW = $clog2(N_REGS);
`ifdef AHB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LAST, S_ERR1, S_ERR2} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic [BW-1:0] be_q, mask;
    logic          write_q, bad_q;
    logic          accept, bad, last;
    logic [OW-1:0] off;
    logic [31:0]   widx;
    logic          unused;

    assign unused    = ^{haddr[31:ADDR_W], htrans[0]};
    assign accept    = hsel & htrans[1] & hready & hreadyout;
    assign reg_addr  = idx_q;
    assign reg_wdata = hwdata;

    // Address-phase decode: legality and the contiguous byte-lane mask
    always_comb begin
        off  = haddr[OW-1:0];
        widx = 32'(haddr[ADDR_W-1:OW]);
        bad  = (hsize > 3'(OW)) || (|(off & OW'((32'd1 << hsize) - 32'd1))) || (widx >= 32'(N_REGS));
        mask = '0;
        for (int b = 0; b < BW; b++)
            mask[b] = (b >= int'(off)) && (b < int'(off) + int'(32'd1 << hsize));
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            be_q    <= '0;
            write_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                idx_q   <= haddr[OW +: AW];
                be_q    <= mask;
                write_q <= hwrite;
                bad_q   <= bad;
            end
        end
    end

    // IDLE, LAST and ERR2 all present hreadyout=1, so each takes a new transfer the same way
    always_comb begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (state_q == S_WAIT) begin
            state_d = (cnt_q == 4'd1) ? S_LAST : S_WAIT;
            cnt_d   = cnt_q - 4'd1;
        end else if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (accept) begin
            state_d = (bad && ERR_EN) ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_LAST;
            cnt_d   = (bad && ERR_EN) ? 4'd0 : 4'(WAIT_STATES);
        end
    end

    always_comb begin
        hreadyout = !(state_q inside {S_WAIT, S_ERR1});
        hresp     = (state_q inside {S_ERR1, S_ERR2}) ? 2'b01 : 2'b00;
        last      = (state_q == S_LAST) && !bad_q;
        reg_we    = last && write_q;
        reg_re    = last && !write_q;
        reg_be    = reg_we ? be_q : '0;
        hrdata    = reg_re ? reg_rdata : '0;
    end
endmodule
